// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative (or optional single-cycle) multiply and restoring divide.
// Operands and results use valid/ready handshakes, and all outputs are registered.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// BUSY  | iterative MUL/DIV step, WIDTH cycles counted down by cnt
// DONE  | out_valid high, outputs held until out_ready
module alu_mdu #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             sign,
    output logic             div_by_zero
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    logic [SW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q, mc_q;
    logic               mul_q, neg_q, negr_q;

    logic               accept, is_mul, is_div, is_signed, b_zero, iter_op;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_lo, alu_hi;
    logic [2*WIDTH-1:0] smul, umul;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign is_mul    = (op == 5'd13) || (op == 5'd14);
    assign is_div    = (op == 5'd15) || (op == 5'd16);
    assign is_signed = (op == 5'd13) || (op == 5'd15);
    assign b_zero    = (b == '0);
    assign iter_op   = (is_mul && !FAST_MUL) || (is_div && !b_zero);
    assign shamt     = a[SW-1:0];

    assign smul  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign umul  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // single-cycle results; divide by zero is resolved here too
    always_comb begin
        alu_lo = a;
        alu_hi = '0;
        case (op)
            5'd1:  alu_lo = a + b;
            5'd2:  alu_lo = a - b;
            5'd3:  alu_lo = a & b;
            5'd4:  alu_lo = a | b;
            5'd5:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            5'd6:  alu_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            5'd7:  alu_lo = a ^ b;
            5'd8:  alu_lo = ~(a | b);
            5'd9:  alu_lo = b << shamt;
            5'd10: alu_lo = b >> shamt;
            5'd11: alu_lo = WIDTH'($signed(b) >>> shamt);
            5'd12: alu_lo = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            5'd13: if (FAST_MUL) {alu_hi, alu_lo} = smul;
            5'd14: if (FAST_MUL) {alu_hi, alu_lo} = umul;
            5'd15, 5'd16: begin
                alu_lo = '1;
                alu_hi = a;
            end
            default: alu_lo = a;
        endcase
    end

    // one shift-add or restoring-divide step on magnitudes
    logic [WIDTH:0]     msum, rs, diff;
    logic [WIDTH-1:0]   step_hi, step_lo, quo_fix, rem_fix, fin_lo, fin_hi;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
        rs   = {hi_q, lo_q[WIDTH-1]};
        diff = rs - {1'b0, mc_q};
        if (mul_q) begin
            step_hi = msum[WIDTH:1];
            step_lo = {msum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = negr_q ? -step_hi : step_hi;
        if (mul_q) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else begin
            fin_hi = rem_fix;
            fin_lo = quo_fix;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = iter_op ? BUSY : DONE;
            BUSY: if (cnt == '0) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mc_q        <= '0;
            mul_q       <= 1'b0;
            neg_q       <= 1'b0;
            negr_q      <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            sign        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (iter_op) begin
                cnt    <= SW'(WIDTH-1);
                hi_q   <= '0;
                mul_q  <= is_mul;
                mc_q   <= is_mul ? mag_a : mag_b;
                lo_q   <= is_mul ? mag_b : mag_a;
                neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                negr_q <= is_signed && a[WIDTH-1];
            end else begin
                result      <= alu_lo;
                result_hi   <= alu_hi;
                zero        <= (alu_lo == '0);
                sign        <= alu_lo[WIDTH-1];
                div_by_zero <= is_div && b_zero;
            end
        end else if (state == BUSY) begin
            if (cnt == '0) begin
                result      <= fin_lo;
                result_hi   <= fin_hi;
                zero        <= (fin_lo == '0);
                sign        <= fin_lo[WIDTH-1];
                div_by_zero <= 1'b0;
            end else begin
                hi_q <= step_hi;
                lo_q <= step_lo;
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: a 32-bit iterative instance and a 16-bit FAST_MUL instance,
// directed corner cases plus random ops compared against an arithmetic reference model.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  iv, ordy, ir, ov, zr, sg, dz;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [31:0] r0, h0;
    logic [15:0] r1, h1;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32), .FAST_MUL(1'b0)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]), .op(op),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(ordy[0]), .result(r0),
        .result_hi(h0), .zero(zr[0]), .sign(sg[0]), .div_by_zero(dz[0]));

    alu_mdu #(.WIDTH(16), .FAST_MUL(1'b1)) dut16 (
        .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]), .op(op),
        .a(a[15:0]), .b(b[15:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(r1),
        .result_hi(h1), .zero(zr[1]), .sign(sg[1]), .div_by_zero(dz[1]));

    function automatic logic [31:0] get_r(input int s);
        return (s != 0) ? {16'h0, r1} : r0;
    endfunction

    function automatic logic [31:0] get_h(input int s);
        return (s != 0) ? {16'h0, h1} : h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: plain signed/unsigned integer arithmetic on w-bit values
    function automatic void model(input int w, input int o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] h, output logic d);
        longint m, ua, ub, sa, sb, p, rr, hh;
        int sh;
        m  = (longint'(1) << w) - 1;
        ua = longint'(x) & m;
        ub = longint'(y) & m;
        sa = ua;
        sb = ub;
        if (ua[w-1]) sa = ua - (longint'(1) << w);
        if (ub[w-1]) sb = ub - (longint'(1) << w);
        sh = int'(ua % w);
        rr = ua; hh = 0; d = 1'b0;
        case (o)
            1:  rr = ua + ub;
            2:  rr = ua - ub;
            3:  rr = ua & ub;
            4:  rr = ua | ub;
            5:  rr = (sa < sb) ? 1 : 0;
            6:  rr = (ua < ub) ? 1 : 0;
            7:  rr = ua ^ ub;
            8:  rr = ~(ua | ub);
            9:  rr = ub << sh;
            10: rr = ub >> sh;
            11: rr = sb >>> sh;
            12: rr = ub << (w / 2);
            13: begin p = sa * sb; rr = p; hh = p >>> w; end
            14: begin p = ua * ub; rr = p; hh = p >> w; end
            15: if (ub == 0) begin rr = m; hh = ua; d = 1'b1; end
                else begin rr = sa / sb; hh = sa % sb; end
            16: if (ub == 0) begin rr = m; hh = ua; d = 1'b1; end
                else begin rr = ua / ub; hh = ua % ub; end
            default: rr = ua;
        endcase
        r = 32'(rr & m);
        h = 32'(hh & m);
    endfunction

    task automatic run_op(input int s, input int o, input logic [31:0] x, input logic [31:0] y, input string tag);
        int w, elat, lat;
        logic [31:0] er, eh;
        logic edz, ynz;
        w   = (s != 0) ? 16 : 32;
        ynz = (s != 0) ? (y[15:0] != 16'h0) : (y != 32'h0);
        model(w, o, x, y, er, eh, edz);
        elat = 1;
        if (((o == 13 || o == 14) && s == 0) || ((o == 15 || o == 16) && ynz)) elat = w + 1;
        @(negedge clk);
        op = 5'(o); a = x; b = y; iv[s] = 1'b1;
        chk({tag, " in_ready"}, 32'(ir[s]), 32'd1);
        @(posedge clk);
        #1 iv[s] = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (ov[s]) break;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " result"}, get_r(s), er);
        chk({tag, " result_hi"}, get_h(s), eh);
        chk({tag, " zero"}, 32'(zr[s]), 32'(er == 32'h0));
        chk({tag, " sign"}, 32'(sg[s]), 32'(er[w-1]));
        chk({tag, " div_by_zero"}, 32'(dz[s]), 32'(edz));
        ordy[s] = 1'b1;
        @(posedge clk);
        #1 ordy[s] = 1'b0;
    endtask

    function automatic logic [31:0] pick(input int s);
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return (s != 0) ? 32'h0000_8000 : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rstn = 1'b0; iv = '0; ordy = '0; op = '0; a = '0; b = '0;
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("reset in_ready", 32'(ir[s]), 32'd1);
            chk("reset out_valid", 32'(ov[s]), 32'd0);
            chk("reset result", get_r(s), 32'h0);
            chk("reset result_hi", get_h(s), 32'h0);
            chk("reset div_by_zero", 32'(dz[s]), 32'd0);
        end
        @(negedge clk) rstn = 1'b1;

        for (int s = 0; s < 2; s++) begin
            run_op(s, 1, 32'h7FFF_FFFF, 32'h1, "add wrap");
            run_op(s, 11, 32'h24, 32'hF000_F000, "sra");
            run_op(s, 5, 32'hFFFF_FFFF, 32'h1, "slt");
            run_op(s, 6, 32'hFFFF_FFFF, 32'h1, "sltu");
            run_op(s, 12, 32'h0, 32'h1234_ABCD, "lui");
            run_op(s, 13, 32'hFFFF_FFFD, 32'h7, "mul");
            run_op(s, 14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu");
            run_op(s, 15, 32'hFFFF_FFF9, 32'h2, "div");
            run_op(s, 16, 32'd100, 32'h0, "divu by zero");
            run_op(s, 15, 32'hFFFF_8000, 32'h0, "div by zero");
            run_op(s, 15, (s != 0) ? 32'h8000 : 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
            run_op(s, 20, 32'h55AA, 32'h1, "nop op20");
        end

        // hold outputs with a pending producer
        @(negedge clk);
        op = 5'd1; a = 32'd5; b = 32'd6; iv[0] = 1'b1;
        @(posedge clk);
        #1 op = 5'd1; a = 32'd100; b = 32'd23;
        @(negedge clk);
        chk("hold first valid", 32'(ov[0]), 32'd1);
        chk("hold first result", r0, 32'd11);
        repeat (10) begin
            @(negedge clk);
            chk("hold result", r0, 32'd11);
            chk("hold in_ready", 32'(ir[0]), 32'd0);
            chk("hold out_valid", 32'(ov[0]), 32'd1);
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        @(negedge clk);
        chk("release out_valid", 32'(ov[0]), 32'd0);
        chk("release in_ready", 32'(ir[0]), 32'd1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(negedge clk);
        chk("second op valid", 32'(ov[0]), 32'd1);
        chk("second op result", r0, 32'd123);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1 ordy[0] = 1'b0;

        // reset aborts an in-flight divide
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            op = 5'd16; a = 32'd1000; b = 32'd7; iv[s] = 1'b1;
            @(posedge clk);
            #1 iv[s] = 1'b0;
            repeat (5) @(negedge clk);
            rstn = 1'b0;
            #1;
            chk("abort out_valid", 32'(ov[s]), 32'd0);
            chk("abort in_ready", 32'(ir[s]), 32'd1);
            chk("abort result", get_r(s), 32'h0);
            chk("abort result_hi", get_h(s), 32'h0);
            @(negedge clk) rstn = 1'b1;
            run_op(s, 1, 32'd1234, 32'd4321, "add after reset");
        end

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40; i++) begin
                run_op(s, int'($urandom_range(0, 31)), pick(s), pick(s), "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
